// File: rtl/ex_mem_pipeline.sv
// EX/MEM pipeline register: one-cycle latency, priority reset > flush > stall > load.
// Branch resolution (pc_src_out, branch_target_out) is compiled in only with `define EX_MEM_BRANCH_EN.
module ex_mem_pipeline (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic        stall,
  input  logic        flush,
  input  logic [63:0] alu_result,
  input  logic        zero,
  input  logic        great,
  input  logic [63:0] rs2_data,
  input  logic [63:0] branch_target,
  input  logic [4:0]  rd,
  input  logic [2:0]  funct3,
  input  logic        branch,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic        mem_to_reg,
  input  logic        reg_write,
  output logic        out_valid,
  output logic [63:0] alu_result_out,
  output logic [63:0] rs2_data_out,
  output logic [63:0] branch_target_out,
  output logic [4:0]  rd_out,
  output logic        mem_read_out,
  output logic        mem_write_out,
  output logic        mem_to_reg_out,
  output logic        reg_write_out,
  output logic        pc_src_out
);

  typedef struct packed {
    logic        valid;
    logic [63:0] alu;
    logic [63:0] rs2;
    logic [63:0] bt;
    logic [4:0]  rd;
    logic        mr;
    logic        mw;
    logic        m2r;
    logic        rw;
    logic        pcs;
  } exmem_t;

  exmem_t q, d;
  logic   cond;

`ifdef EX_MEM_BRANCH_EN
  always_comb begin
    cond = 1'b0;
    case (funct3)
      3'b000:  cond = zero;
      3'b001:  cond = ~zero;
      3'b100:  cond = ~zero & ~great;
      3'b101:  cond = zero | great;
      default: cond = 1'b0;
    endcase
  end
`else
  // Branch inputs are intentionally ignored in this build.
  logic unused_branch;
  assign cond          = 1'b0;
  assign unused_branch = ^{zero, great, funct3, branch, branch_target};
`endif

  always_comb begin
    d = q;
    if (flush) begin
      d = '0;
    end else if (!stall) begin
      d.valid = in_valid;
      d.alu   = alu_result;
      d.rs2   = rs2_data;
      d.rd    = rd;
      // Control bits are gated so a bubble can never write memory or the RF.
      d.mr    = mem_read   & in_valid;
      d.mw    = mem_write  & in_valid;
      d.m2r   = mem_to_reg & in_valid;
      d.rw    = reg_write  & in_valid;
`ifdef EX_MEM_BRANCH_EN
      d.bt    = branch_target;
      d.pcs   = in_valid & branch & cond;
`else
      d.bt    = '0;
      d.pcs   = cond;
`endif
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) q <= '0;
    else        q <= d;
  end

  assign out_valid         = q.valid;
  assign alu_result_out    = q.alu;
  assign rs2_data_out      = q.rs2;
  assign branch_target_out = q.bt;
  assign rd_out            = q.rd;
  assign mem_read_out      = q.mr;
  assign mem_write_out     = q.mw;
  assign mem_to_reg_out    = q.m2r;
  assign reg_write_out     = q.rw;
  assign pc_src_out        = q.pcs;

endmodule

// File: tb/tb_ex_mem_pipeline.sv
// Self-checking bench for ex_mem_pipeline: directed scenarios then randomized traffic
// checked against a behavioural model of the EX/MEM register.
module tb_ex_mem_pipeline;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 0, stall = 0, flush = 0;
  logic [63:0] alu_result = '0, rs2_data = '0, branch_target = '0;
  logic        zero = 0, great = 0;
  logic [4:0]  rd = '0;
  logic [2:0]  funct3 = '0;
  logic        branch = 0, mem_read = 0, mem_write = 0, mem_to_reg = 0, reg_write = 0;

  logic        out_valid, mem_read_out, mem_write_out, mem_to_reg_out, reg_write_out, pc_src_out;
  logic [63:0] alu_result_out, rs2_data_out, branch_target_out;
  logic [4:0]  rd_out;

  int total = 0;
  int bad   = 0;

  // Expected register contents.
  logic        e_v, e_mr, e_mw, e_m2r, e_rw, e_pcs;
  logic [63:0] e_alu, e_rs2, e_bt;
  logic [4:0]  e_rd;

`ifdef EX_MEM_BRANCH_EN
  localparam bit BR_EN = 1'b1;
`else
  localparam bit BR_EN = 1'b0;
`endif

  ex_mem_pipeline dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .stall(stall), .flush(flush),
    .alu_result(alu_result), .zero(zero), .great(great), .rs2_data(rs2_data),
    .branch_target(branch_target), .rd(rd), .funct3(funct3), .branch(branch),
    .mem_read(mem_read), .mem_write(mem_write), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .out_valid(out_valid), .alu_result_out(alu_result_out), .rs2_data_out(rs2_data_out),
    .branch_target_out(branch_target_out), .rd_out(rd_out), .mem_read_out(mem_read_out),
    .mem_write_out(mem_write_out), .mem_to_reg_out(mem_to_reg_out),
    .reg_write_out(reg_write_out), .pc_src_out(pc_src_out)
  );

  always #5 clk = ~clk;

  // Branch taken rule: beq, bne, blt (neither equal nor greater), bge.
  function automatic bit taken(input logic [2:0] f3, input bit z, input bit g);
    if (f3 == 3'd0) return z;
    if (f3 == 3'd1) return !z;
    if (f3 == 3'd4) return !z && !g;
    if (f3 == 3'd5) return z || g;
    return 1'b0;
  endfunction

  task automatic model_clear();
    {e_v, e_mr, e_mw, e_m2r, e_rw, e_pcs} = '0;
    e_alu = '0; e_rs2 = '0; e_bt = '0; e_rd = '0;
  endtask

  task automatic model_edge();
    if (!reset || flush) model_clear();
    else if (!stall) begin
      e_v   = in_valid;
      e_alu = alu_result;
      e_rs2 = rs2_data;
      e_rd  = rd;
      e_mr  = in_valid && mem_read;
      e_mw  = in_valid && mem_write;
      e_m2r = in_valid && mem_to_reg;
      e_rw  = in_valid && reg_write;
      e_bt  = BR_EN ? branch_target : 64'd0;
      e_pcs = BR_EN && in_valid && branch && taken(funct3, zero, great);
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string ctx);
    chk({ctx, ".out_valid"}, 64'(out_valid), 64'(e_v));
    chk({ctx, ".alu"},       alu_result_out,  e_alu);
    chk({ctx, ".rs2"},       rs2_data_out,    e_rs2);
    chk({ctx, ".bt"},        branch_target_out, e_bt);
    chk({ctx, ".rd"},        64'(rd_out),     64'(e_rd));
    chk({ctx, ".mem_read"},  64'(mem_read_out),  64'(e_mr));
    chk({ctx, ".mem_write"}, 64'(mem_write_out), 64'(e_mw));
    chk({ctx, ".mem_to_reg"},64'(mem_to_reg_out),64'(e_m2r));
    chk({ctx, ".reg_write"}, 64'(reg_write_out), 64'(e_rw));
    chk({ctx, ".pc_src"},    64'(pc_src_out),    64'(e_pcs));
  endtask

  task automatic tick(input string ctx);
    model_edge();
    @(posedge clk);
    #1;
    check_all(ctx);
  endtask

  task automatic idle_inputs();
    in_valid = 0; stall = 0; flush = 0; branch = 0;
    mem_read = 0; mem_write = 0; mem_to_reg = 0; reg_write = 0;
    alu_result = '0; rs2_data = '0; branch_target = '0; rd = '0;
    funct3 = '0; zero = 0; great = 0;
  endtask

  task automatic rand_inputs();
    in_valid      = ($urandom_range(0, 3) != 0);
    alu_result    = {$urandom, $urandom};
    rs2_data      = {$urandom, $urandom};
    branch_target = {$urandom, $urandom};
    rd            = 5'($urandom);
    funct3        = 3'($urandom);
    {zero, great, branch, mem_read, mem_write, mem_to_reg, reg_write} = 7'($urandom);
    stall         = ($urandom_range(0, 3) == 0);
    flush         = ($urandom_range(0, 9) == 0);
  endtask

  initial begin
    model_clear();
    #1;
    check_all("reset_state");

    // Inputs active while reset is held: outputs must stay zero.
    in_valid = 1; reg_write = 1; mem_read = 1; rd = 5'd12; alu_result = 64'h1234;
    tick("in_reset");
    stall = 1; flush = 1;
    tick("in_reset_sf");
    idle_inputs();

    #3 reset = 1'b1;

    // First load directly after reset release.
    in_valid = 1; alu_result = 64'h0000_0000_DEAD_BEEF; rd = 5'd7; reg_write = 1;
    tick("load");
    chk("load.alu_const", alu_result_out, 64'hDEADBEEF);
    chk("load.rd_const",  64'(rd_out), 64'd7);

    // Bubble: controls gated by in_valid.
    idle_inputs();
    mem_write = 1; reg_write = 1; alu_result = 64'hFFFF_FFFF_FFFF_FFFF;
    tick("bubble");
    chk("bubble.mem_write_const", 64'(mem_write_out), 64'd0);

    // Stall holds, then flush wins over stall.
    idle_inputs();
    in_valid = 1; rd = 5'd3; reg_write = 1; alu_result = 64'hAAAA;
    tick("pre_stall");
    rd = 5'd9; alu_result = 64'h5555; stall = 1;
    for (int i = 0; i < 3; i++) tick("stall");
    chk("stall.rd_const", 64'(rd_out), 64'd3);
    flush = 1;
    tick("flush");
    chk("flush.rd_const", 64'(rd_out), 64'd0);

    // Stall release resumes with the slot present at that edge, then back-to-back loads.
    stall = 1; flush = 0; rd = 5'd11;
    tick("stall2");
    stall = 0; rd = 5'd13;
    tick("release");
    for (int i = 0; i < 4; i++) begin
      rd = 5'(20 + i); alu_result = 64'(i);
      tick("b2b");
    end

    // Branch conditions.
    idle_inputs();
    in_valid = 1; branch = 1; branch_target = 64'h8000_0000_0000_0040;
    funct3 = 3'b000; zero = 1;
    tick("br_beq");
    chk("br_beq.const", 64'(pc_src_out), 64'(BR_EN));
    funct3 = 3'b001;
    tick("br_bne");
    chk("br_bne.const", 64'(pc_src_out), 64'd0);
    funct3 = 3'b101; zero = 0; great = 1;
    tick("br_bge");
    chk("br_bge.const", 64'(pc_src_out), 64'(BR_EN));
    for (int f = 0; f < 8; f++) begin
      for (int zg = 0; zg < 4; zg++) begin
        funct3 = 3'(f); {zero, great} = 2'(zg);
        tick("br_sweep");
      end
    end

    // Async reset mid-cycle, then release and reload.
    idle_inputs();
    in_valid = 1; rd = 5'd17; reg_write = 1; alu_result = 64'hCAFE;
    tick("pre_areset");
    #3 reset = 1'b0;
    #1 model_clear();
    check_all("areset");
    #2 reset = 1'b1;
    tick("post_areset");

    // Randomized traffic with occasional asynchronous reset pulses.
    for (int n = 0; n < 400; n++) begin
      rand_inputs();
      if ($urandom_range(0, 39) == 0) begin
        #2 reset = 1'b0;
        #1 model_clear();
        check_all("rnd_areset");
        #1 reset = 1'b1;
      end
      tick("rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule
